// File: rtl/pipe_pkg.sv
// Shared constants for the generic pipeline stage register and the ID/EX
// vector layout used by ID, EX and the hazard unit.
package pipe_pkg;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] TWO   = 2'b10;

  // ID/EX control vector layout
  localparam int IDEX_CTRL_W  = 40;
  localparam int C_REGWRITE   = 0;
  localparam int C_MEMWRITE   = 1;
  localparam int C_MEMTOREG   = 2;
  localparam int C_ALUSRC     = 3;
  localparam int C_REGDST     = 4;
  localparam int C_BRANCH     = 5;
  localparam int C_JUMP       = 6;
  localparam int C_ALUCTR_LSB = 7;
  localparam int C_ALUCTR_W   = 4;
  localparam int C_EXCEPT_LSB = 11;
  localparam int C_EXCEPT_W   = 8;

  // ID/EX data vector layout; the top bit is reserved
  localparam int IDEX_DATA_W  = 165;
  localparam int D_PC_LSB     = 0;
  localparam int D_INSTR_LSB  = 32;
  localparam int D_BUSA_LSB   = 64;
  localparam int D_BUSB_LSB   = 96;
  localparam int D_IMM_LSB    = 128;
  localparam int D_IMM_W      = 16;
  localparam int D_RS_LSB     = 144;
  localparam int D_RT_LSB     = 149;
  localparam int D_RD_LSB     = 154;
  localparam int D_SHAMT_LSB  = 159;
  localparam int D_REG_W      = 5;

  function automatic logic [D_REG_W-1:0] idex_rd(input logic [IDEX_DATA_W-1:0] d);
    return d[D_RD_LSB +: D_REG_W];
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One {valid, ctrl, data} pipeline entry. clr zeroes everything, load captures
// a new entry, kill turns the entry into a bubble (ctrl zeroed, data held).
module pipe_skid_slot #(
  parameter int CTRL_W = 40,
  parameter int DATA_W = 165
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic              kill,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= in_ctrl;
      data  <= in_data;
    end else if (kill) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic handshaked inter-stage register with stall/flush, bubble insertion,
// optional skid entry and a saturating backpressure counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 40,
  parameter int DATA_W = 165,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [1:0]        state;
  logic              accept, drain;
  logic              main_load, main_kill;
  logic [CTRL_W-1:0] main_ctrl_in;
  logic [DATA_W-1:0] main_data_in;

  assign state  = skid_valid ? TWO : (main_valid ? ONE : EMPTY);
  assign accept = in_valid & in_ready;
  // stall blocks the drain even if downstream shows ready
  assign drain  = !stall & main_valid & out_ready;

  // main refills from skid when it holds an entry, else from the input
  assign main_load    = (accept & ((state == EMPTY) | drain)) | ((state == TWO) & drain);
  assign main_kill    = drain & !accept & (state == ONE);
  assign main_ctrl_in = (state == TWO) ? skid_ctrl : in_ctrl;
  assign main_data_in = (state == TWO) ? skid_data : in_data;

  pipe_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .clr     (flush),
    .load    (main_load),
    .kill    (main_kill),
    .in_ctrl (main_ctrl_in),
    .in_data (main_data_in),
    .valid   (main_valid),
    .ctrl    (out_ctrl),
    .data    (out_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic skid_load, skid_kill;
      assign skid_load = accept & (state == ONE) & !drain;
      assign skid_kill = drain & (state == TWO);
      // depends only on registered state, never on out_ready
      assign in_ready  = reset & !stall & (state != TWO);

      pipe_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .clr     (flush),
        .load    (skid_load),
        .kill    (skid_kill),
        .in_ctrl (in_ctrl),
        .in_data (in_data),
        .valid   (skid_valid),
        .ctrl    (skid_ctrl),
        .data    (skid_data)
      );
    end else begin : g_noskid
      assign in_ready   = reset & !stall & (!main_valid | out_ready);
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
    end
  endgenerate

  assign out_valid = main_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
